vga_stream_out: RTL



---
 rtl/vga_stream_if.sv | 20 ++
 rtl/vga_stream_out.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_if.sv
// Avalon-ST RGB pixel stream bundle feeding the VGA output stage.
interface vga_stream_if #(
  parameter int COLOR_BITS = 8
);
  logic [3*COLOR_BITS-1:0] in_data;
  logic                    in_startofpacket;
  logic                    in_endofpacket;
  logic                    in_valid;
  logic                    in_ready;

  modport master (
    output in_data, in_startofpacket, in_endofpacket, in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data, in_startofpacket, in_endofpacket, in_valid,
    output in_ready
  );
endinterface

// File: rtl/vga_stream_out.sv
// vga_stream_out: parametrised VGA timing generator fed by an Avalon-ST
// RGB stream through a show-ahead FIFO. Each frame is locked to the
// stream's start-of-packet; underflow and misplaced SOPs drop lock and the
// block re-seeks the next SOP on its own.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a test_pattern input that
// replaces a frame with 8 vertical colour bars.
module vga_stream_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_BITS = 8,
  parameter int SYNC_POL   = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  vga_stream_if.slave           sink,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                  test_pattern,
`endif
  output logic                  vga_HS,
  output logic                  vga_VS,
  output logic                  vga_BLANK,
  output logic                  vga_SYNC,
  output logic [COLOR_BITS-1:0] vga_R,
  output logic [COLOR_BITS-1:0] vga_G,
  output logic [COLOR_BITS-1:0] vga_B,
  output logic                  frame_start,
  output logic                  frame_error
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = 3 * COLOR_BITS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
  localparam logic          SP     = (SYNC_POL != 0);

  typedef enum logic {SEEK, LOCKED} state_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, at00, hs_win, vs_win;

  logic [DW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          ready_r, push, pop;
  logic          head_vld, head_sop;
  logic [DW-1:0] head_data;

  state_t        state, state_nxt;
  logic          show, err, fs_c, tp_now;

  logic [DW-1:0] rgb_r;

  // eop carries no meaning for this sink
  logic unused_eop;
  assign unused_eop = sink.in_endofpacket;

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign at00   = (h_cnt == '0) && (v_cnt == '0);
  assign hs_win = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_win = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  // Raster counters: h wraps each line, v advances on the h wrap.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Show-ahead FIFO: the head is only valid once an entry is stored, so a
  // same-cycle push into an empty FIFO is never popped.
  assign head_vld              = (count != '0);
  assign {head_sop, head_data} = mem[rd_ptr];
  assign push                  = sink.in_valid && ready_r;
  assign sink.in_ready         = ready_r;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers and registered ready (low in reset, then !full).
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      ready_r <= (count_nxt != DEPTH);
    end
  end

  // FIFO storage: pixel plus its SOP flag.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= {sink.in_startofpacket, sink.in_data};
  end

`ifdef VGA_TEST_PATTERN_EN
  logic          tp_frame;
  logic [HW+2:0] bar_idx;
  localparam int BW = HW + 3;

  // The test_pattern choice made at (0,0) holds for the whole frame.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)  tp_frame <= 1'b0;
    else if (at00)    tp_frame <= test_pattern;
  end

  assign tp_now  = at00 ? test_pattern : tp_frame;
  assign bar_idx = {h_cnt, 3'b000} / BW'(H_ACTIVE);
`else
  assign tp_now = 1'b0;
`endif

  // Lock state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= SEEK;
    else             state <= state_nxt;
  end

  // Lock FSM: SEEK drains non-SOP entries and waits for SOP at (0,0);
  // LOCKED pops one entry per active position and drops lock on any
  // underflow or SOP/position disagreement. Test-pattern frames freeze it.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    show      = 1'b0;
    err       = 1'b0;
    fs_c      = 1'b0;
    if (!tp_now) begin
      case (state)
        SEEK: begin
          if (head_vld) begin
            if (!head_sop) begin
              pop = 1'b1;
            end else if (at00) begin
              pop       = 1'b1;
              show      = 1'b1;
              fs_c      = 1'b1;
              state_nxt = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (active) begin
            if (!head_vld || (head_sop != at00)) begin
              err       = 1'b1;
              state_nxt = SEEK;
            end else begin
              pop  = 1'b1;
              show = 1'b1;
              fs_c = at00;
            end
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  // Registered video outputs, all aligned one cycle behind the counters.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      vga_HS      <= !SP;
      vga_VS      <= !SP;
      vga_BLANK   <= 1'b0;
      rgb_r       <= '0;
      frame_start <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      vga_HS      <= hs_win ? SP : !SP;
      vga_VS      <= vs_win ? SP : !SP;
      vga_BLANK   <= active;
      frame_start <= fs_c;
      frame_error <= err;
`ifdef VGA_TEST_PATTERN_EN
      if (tp_now && active)
        rgb_r <= {{COLOR_BITS{bar_idx[2]}}, {COLOR_BITS{bar_idx[1]}},
                  {COLOR_BITS{bar_idx[0]}}};
      else
        rgb_r <= show ? head_data : '0;
`else
      rgb_r <= show ? head_data : '0;
`endif
    end
  end

  assign vga_SYNC = 1'b0;
  assign vga_R    = rgb_r[DW-1 -: COLOR_BITS];
  assign vga_G    = rgb_r[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_B    = rgb_r[COLOR_BITS-1:0];
endmodule
